// File: rtl/ula_16bits_seq.sv
// ============================================================================
// ula_8bits / ula_16bits_seq
//
// ula_8bits: 8-bit combinational ALU with 74181 behaviour (active-high data,
// active-low carry). Sixteen logic functions when m=1, sixteen arithmetic
// functions when m=0.
//   i_a, i_b   8-bit operands
//   i_s        4-bit function select
//   i_m        1 = logic, 0 = arithmetic
//   i_c_in     carry in, active-low (1 = no carry)
//   o_f        8-bit result
//   o_c_out    carry out, active-low (0 = carry generated)
//   o_a_eq_b   high when o_f is all ones
//
// ula_16bits_seq: 16-bit ALU built from a single ula_8bits used twice.
// The low byte is computed first, then the high byte, with the low-pass carry
// rippled into the high pass. Requests arrive on a valid/ready handshake and
// results leave on a valid/ready handshake.
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (ready only in IDLE)
//   a, b, s, m, c_in    operands, function select, mode, active-low carry in
//   out_valid/out_ready result handshake (valid only in DONE)
//   f, c_out, a_eq_b    16-bit result, active-low carry out, A=B flag
//   busy                high whenever the FSM is not in IDLE
// ============================================================================

module ula_8bits (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_c_in,
    output logic [7:0] o_f,
    output logic       o_c_out,
    output logic       o_a_eq_b
);

    logic [7:0] w_x;
    logic [7:0] w_y;
    logic [8:0] w_sum;

    // The 74181 forms two per-bit terms from the select lines and adds them.
    // Every arithmetic row of the function table is w_x plus w_y plus carry,
    // and every logic row is the XNOR of the same two terms.
    assign w_x   = i_a | (i_b & {8{i_s[0]}}) | (~i_b & {8{i_s[1]}});
    assign w_y   = (i_a & ~i_b & {8{i_s[2]}}) | (i_a & i_b & {8{i_s[3]}});
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {8'b0, ~i_c_in};

    // The carry chain is evaluated in both modes, as on the original chip.
    assign o_f      = i_m ? ~(w_x ^ w_y) : w_sum[7:0];
    assign o_c_out  = ~w_sum[8];
    assign o_a_eq_b = &o_f;

endmodule

module ula_16bits_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  s,
    input  logic        m,
    input  logic        c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] f,
    output logic        c_out,
    output logic        a_eq_b,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [3:0]  r_s;
    logic        r_m;
    logic        r_c_in;

    logic [7:0]  r_f_lo;
    logic        r_lo_c_out;
    logic        r_lo_a_eq_b;

    logic [15:0] r_f;
    logic        r_c_out;
    logic        r_a_eq_b;

    logic [7:0]  w_alu_a;
    logic [7:0]  w_alu_b;
    logic        w_alu_c_in;
    logic [7:0]  w_alu_f;
    logic        w_alu_c_out;
    logic        w_alu_a_eq_b;

    // In HIGH the ALU sees the upper bytes and the low-pass carry straight
    // through; in every other state it sees the lower bytes and the latched
    // carry in, which is what LOW needs.
    assign w_alu_a    = (r_state == HIGH) ? r_a[15:8] : r_a[7:0];
    assign w_alu_b    = (r_state == HIGH) ? r_b[15:8] : r_b[7:0];
    assign w_alu_c_in = (r_state == HIGH) ? r_lo_c_out : r_c_in;

    ula_8bits u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_s      (r_s),
        .i_m      (r_m),
        .i_c_in   (w_alu_c_in),
        .o_f      (w_alu_f),
        .o_c_out  (w_alu_c_out),
        .o_a_eq_b (w_alu_a_eq_b)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs. Outputs decode straight from the
    // state register, so reset takes effect on them without a clock edge.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next_state = LOW;
                end
            end
            LOW: begin
                w_next_state = HIGH;
            end
            HIGH: begin
                w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. The low pass lands in staging registers so the
    // visible result keeps the previous answer until the high pass writes
    // all 16 bits at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_s         <= 4'h0;
            r_m         <= 1'b0;
            r_c_in      <= 1'b0;
            r_f_lo      <= 8'h00;
            r_lo_c_out  <= 1'b1;
            r_lo_a_eq_b <= 1'b0;
            r_f         <= 16'h0000;
            r_c_out     <= 1'b1;
            r_a_eq_b    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_s    <= s;
                        r_m    <= m;
                        r_c_in <= c_in;
                    end
                end
                LOW: begin
                    r_f_lo      <= w_alu_f;
                    r_lo_c_out  <= w_alu_c_out;
                    r_lo_a_eq_b <= w_alu_a_eq_b;
                end
                HIGH: begin
                    r_f      <= {w_alu_f, r_f_lo};
                    r_c_out  <= w_alu_c_out;
                    r_a_eq_b <= r_lo_a_eq_b & w_alu_a_eq_b;
                end
                default: begin
                end
            endcase
        end
    end

    assign f      = r_f;
    assign c_out  = r_c_out;
    assign a_eq_b = r_a_eq_b;

endmodule

// File: tb/tb_ula_16bits_seq.sv
// ============================================================================
// tb_ula_16bits_seq
//
// Directed vectors for the two-pass 16-bit ALU. The driver pushes the
// hand-computed answer into a queue as each request is accepted; an
// independent monitor pops and compares whenever a result is handed over,
// and also checks how many edges the result took to appear.
// ============================================================================

module tb_ula_16bits_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        c_out;
    logic        a_eq_b;
    logic        busy;

    typedef struct {
        logic [15:0] f;
        logic        c_out;
        logic        a_eq_b;
        int          acceptEdge;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t monExp;

    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    logic prevValid = 1'b0;

    always #5 clk = ~clk;

    ula_16bits_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .c_out     (c_out),
        .a_eq_b    (a_eq_b),
        .busy      (busy)
    );

    // Edge counter used to measure latency from the accepting edge.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one request. The answer is queued only when track is set, so an
    // operation that reset will abandon leaves nothing behind to match.
    task automatic applyStimulus(input string name, input logic [15:0] aV,
                                 input logic [15:0] bV, input logic [3:0] sV,
                                 input logic mV, input logic cV,
                                 input logic [15:0] expF, input logic expC,
                                 input logic expEq, input bit track);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait_ready: got in_ready=0 after 20 cycles, expected 1", name);
            return;
        end
        in_valid = 1'b1;
        a        = aV;
        b        = bV;
        s        = sV;
        m        = mV;
        c_in     = cV;
        @(posedge clk);
        #1;
        if (track) sb.push_back('{expF, expC, expEq, cycle, name});
        // Scramble the inputs so a design that fails to latch gets caught.
        in_valid = 1'b0;
        a        = ~aV;
        b        = ~bV;
        s        = ~sV;
        m        = ~mV;
        c_in     = ~cV;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: measures latency on the rising edge of out_valid and compares
    // the result against the oldest queued answer when it is consumed.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (out_valid && !prevValid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected 0 with nothing pending");
                end else begin
                    // Accepting edge moves to LOW, the next to HIGH, the next
                    // to DONE: valid shows on the third edge counting the
                    // accepting one.
                    checkOutput({sb[0].name, "_latency"}, cycle - sb[0].acceptEdge, 2);
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                monExp = sb.pop_front();
                checkOutput({monExp.name, "_f"}, f, monExp.f);
                checkOutput({monExp.name, "_c_out"}, c_out, monExp.c_out);
                checkOutput({monExp.name, "_a_eq_b"}, a_eq_b, monExp.a_eq_b);
            end
            prevValid = out_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        s         = 4'h0;
        m         = 1'b0;
        c_in      = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_f", f, 16'h0000);
        checkOutput("reset_c_out", c_out, 1);
        checkOutput("reset_a_eq_b", a_eq_b, 0);
        rst = 1'b0;

        //            name          a        b        s      m     cin   f        c     eq
        applyStimulus("add_ripple", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b1);
        applyStimulus("add_ovf",    16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        applyStimulus("cmp_eq",     16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        applyStimulus("cmp_ne",     16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1);
        applyStimulus("logic_xor",  16'h1234, 16'h00FF, 4'b0110, 1'b1, 1'b1, 16'h12CB, 1'b0, 1'b0, 1'b1);
        applyStimulus("logic_nota", 16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        applyStimulus("add_cin",    16'h00FF, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1);
        applyStimulus("sub",        16'h0003, 16'h0005, 4'b0110, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1);
        waitDrain("directed");

        // Backpressure: hold the result in DONE while the inputs churn.
        out_ready = 1'b0;
        applyStimulus("bp", 16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 16'h2345, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_reach_done", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(negedge clk);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_f_hold", f, 16'h2345);
            checkOutput("bp_c_out_hold", c_out, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready", in_ready, 1);
        checkOutput("bp_release_out_valid", out_valid, 0);
        in_valid = 1'b0;
        waitDrain("bp");

        // Reset in HIGH: the operation is dropped and the result clears.
        applyStimulus("abandon", 16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, 16'h1010, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_in_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_in_ready", in_ready, 1);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_f", f, 16'h0000);
        checkOutput("rst_mid_c_out", c_out, 1);
        checkOutput("rst_mid_a_eq_b", a_eq_b, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        applyStimulus("after_rst", 16'h8001, 16'h8001, 4'b1001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        waitDrain("after_rst");
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
